// File: rtl/gray_counter_if.sv
// Control and result signals of the Gray/binary up-down counter.
// master drives the controls; slave is the counter itself.
interface gray_counter_if #(
   parameter int WIDTH = 8
);
   logic             clr;
   logic             load;
   logic             load_gray;
   logic [WIDTH-1:0] din;
   logic             en;
   logic             up;
   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] gray_q;
   logic             wrap;

   modport master (
      output clr, load, load_gray, din, en, up,
      input  bin_q, gray_q, wrap
   );

   modport slave (
      input  clr, load, load_gray, din, en, up,
      output bin_q, gray_q, wrap
   );
endinterface

// File: rtl/gray_counter.sv
// Up/down counter with binary or Gray load.
// Outputs are the binary count, its Gray code and a wrap pulse, all registered.
module gray_counter #(
   parameter int WIDTH = 8
) (
   input logic         clk,
   input logic         rst_n,
   gray_counter_if.slave cnt_if
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic [WIDTH-1:0] din_bin;
   logic             wrap_q, wrap_d;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      din_bin = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         din_bin[i] = ^(cnt_if.din >> i);
      end
   end

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (cnt_if.clr) begin
         count_d = '0;
      end else if (cnt_if.load) begin
         count_d = cnt_if.load_gray ? din_bin : cnt_if.din;
      end else if (cnt_if.en) begin
         if (cnt_if.up) begin
            count_d = count_q + ONE;
            wrap_d  = &count_q;
         end else begin
            count_d = count_q - ONE;
            wrap_d  = ~|count_q;
         end
      end
      // Gray code is encoded from the next count so gray_q comes straight from a flop
      gray_d = count_d ^ (count_d >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         gray_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         gray_q  <= gray_d;
         wrap_q  <= wrap_d;
      end
   end

   assign cnt_if.bin_q  = count_q;
   assign cnt_if.gray_q = gray_q;
   assign cnt_if.wrap   = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed corner cases plus randomized
// traffic on an 8-bit instance, and an up/down walk on a 4-bit instance.
module tb_gray_counter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gray_counter_if #(.WIDTH(8)) if8 ();
   gray_counter_if #(.WIDTH(4)) if4 ();

   gray_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .cnt_if(if8.slave));
   gray_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .cnt_if(if4.slave));

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   int unsigned m8 = 0;
   logic        w8 = 1'b0;
   int unsigned m4 = 0;
   logic        w4 = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference Gray code by definition and its inverse by exhaustive search
   function automatic int unsigned to_gray(input int unsigned v);
      return v ^ (v >> 1);
   endfunction

   function automatic int unsigned from_gray(input int unsigned g, input int unsigned w);
      for (int unsigned v = 0; v < (32'd1 << w); v++)
         if (to_gray(v) == g) return v;
      return 0;
   endfunction

   task automatic model_step(inout int unsigned m, inout logic w, input int unsigned width,
                             input logic c, input logic ld, input logic lg,
                             input int unsigned din, input logic e, input logic u);
      int unsigned modv;
      modv = 32'd1 << width;
      w = 1'b0;
      if (c) m = 0;
      else if (ld) m = lg ? from_gray(din, width) : din;
      else if (e) begin
         if (u) begin
            w = (m == modv - 1);
            m = (m + 1) % modv;
         end else begin
            w = (m == 0);
            m = (m + modv - 1) % modv;
         end
      end
   endtask

   task automatic drive8(input logic c, input logic ld, input logic lg,
                         input int unsigned din, input logic e, input logic u, input string tag);
      if8.clr = c; if8.load = ld; if8.load_gray = lg; if8.din = din[7:0]; if8.en = e; if8.up = u;
      @(posedge clk);
      model_step(m8, w8, 8, c, ld, lg, din & 32'hFF, e, u);
      #1;
      check({tag, ".bin"},  32'(if8.bin_q),  m8);
      check({tag, ".gray"}, 32'(if8.gray_q), to_gray(m8));
      check({tag, ".wrap"}, 32'(if8.wrap),   32'(w8));
   endtask

   task automatic drive4(input logic c, input logic e, input logic u, input string tag);
      logic [3:0] prev_gray;
      prev_gray = if4.gray_q;
      if4.clr = c; if4.load = 1'b0; if4.load_gray = 1'b0; if4.din = '0; if4.en = e; if4.up = u;
      @(posedge clk);
      model_step(m4, w4, 4, c, 1'b0, 1'b0, 0, e, u);
      #1;
      check({tag, ".bin"},  32'(if4.bin_q),  m4);
      check({tag, ".gray"}, 32'(if4.gray_q), to_gray(m4));
      check({tag, ".wrap"}, 32'(if4.wrap),   32'(w4));
      if (e && !c)
         check({tag, ".onebit"}, $countones(prev_gray ^ if4.gray_q), 1);
   endtask

   initial begin
      rst_n = 1'b0;
      if8.clr = 1'b0; if8.load = 1'b0; if8.load_gray = 1'b0; if8.din = '0; if8.en = 1'b0; if8.up = 1'b0;
      if4.clr = 1'b0; if4.load = 1'b0; if4.load_gray = 1'b0; if4.din = '0; if4.en = 1'b0; if4.up = 1'b0;
      #2;
      check("rst.bin",  32'(if8.bin_q),  0);
      check("rst.gray", 32'(if8.gray_q), 0);
      check("rst.wrap", 32'(if8.wrap),   0);
      #10 rst_n = 1'b1;

      for (int i = 0; i < 5; i++) drive8(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, "pre_cnt");

      // Asynchronous reset mid-count, well away from any clock edge
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_rst.bin",  32'(if8.bin_q),  0);
      check("async_rst.gray", 32'(if8.gray_q), 0);
      check("async_rst.wrap", 32'(if8.wrap),   0);
      m8 = 0; w8 = 1'b0;
      #1 rst_n = 1'b1;
      drive8(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, "post_rst");

      drive8(1'b0, 1'b1, 1'b0, 32'hBB, 1'b0, 1'b0, "load_bin");
      check("load_bin.gray_lit", 32'(if8.gray_q), 32'hE6);
      drive8(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "hold");
      drive8(1'b0, 1'b1, 1'b1, 32'hE6, 1'b0, 1'b0, "load_gray");
      check("load_gray.bin_lit", 32'(if8.bin_q), 32'hBB);

      drive8(1'b0, 1'b1, 1'b0, 32'hFE, 1'b0, 1'b0, "load_fe");
      for (int i = 0; i < 3; i++) drive8(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, "up_wrap");
      drive8(1'b0, 1'b1, 1'b0, 32'h01, 1'b0, 1'b0, "load_01");
      for (int i = 0; i < 2; i++) drive8(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, "dn_wrap");
      check("dn_wrap.wrap_lit", 32'(if8.wrap), 1);
      drive8(1'b1, 1'b1, 1'b0, 32'h55, 1'b1, 1'b1, "prio_clr");
      drive8(1'b0, 1'b1, 1'b0, 32'hFF, 1'b1, 1'b1, "prio_load_ff");
      drive8(1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0, "prio_load_00");
      // Direction reversal with no dead cycle
      drive8(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, "dir_up");
      drive8(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, "dir_dn");
      drive8(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, "dir_dn2");

      for (int i = 0; i < 300; i++) begin
         logic c, ld, lg, e, u;
         int unsigned d;
         c  = ($urandom_range(0, 15) == 0);
         ld = ($urandom_range(0, 7) == 0);
         lg = 1'($urandom_range(0, 1));
         e  = ($urandom_range(0, 3) != 0);
         u  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: d = 32'hFF;
            1: d = 32'h00;
            default: d = $urandom_range(0, 255);
         endcase
         drive8(c, ld, lg, d, e, u, "rand");
      end
      if8.en = 1'b0; if8.load = 1'b0; if8.clr = 1'b0;

      drive4(1'b1, 1'b0, 1'b0, "w4_clr");
      for (int i = 0; i < 40; i++) drive4(1'b0, 1'b1, 1'b1, "w4_up");
      for (int i = 0; i < 40; i++) drive4(1'b0, 1'b1, 1'b0, "w4_dn");
      drive4(1'b0, 1'b0, 1'b1, "w4_hold");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
